sub_serial3: RTL and testbench

Multi-cycle borrow-chain subtractor that computes `diff = a - b - bin` on WIDTH-bit operands one 3-bit slice per clock. The borrow between slices is held in a register.
- It is the subtract-direction counterpart of the 3-bit ripple-carry adder partition used in our partitioned arithmetic netlists.
- It sits between operand producers and result consumers behind valid/ready handshakes on both sides.
- It trades latency for a small, approximation-friendly 3-bit slice datapath.

---
 rtl/sub_serial3_pkg.sv | 12 +
 rtl/sub_slice3.sv | 15 +
 rtl/sub_serial3.sv | 115 +++++++++++
 tb/tb_sub_serial3.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sub_serial3_pkg.sv
// rtl/sub_serial3_pkg.sv - shared types and sizing for the 3-bit-slice serial subtractor
package sub_serial3_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SLICE_W = 3;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/sub_slice3.sv
// rtl/sub_slice3.sv - combinational 3-bit borrow slice, d = a - b - borrow
module sub_slice3
  import sub_serial3_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               borrow,
  output logic [SLICE_W-1:0] d,
  output logic               borrow_out
);

  // One extra bit captures the borrow as the sign of the 4-bit difference
  assign {borrow_out, d} = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, borrow};

endmodule

// File: rtl/sub_serial3.sv
// rtl/sub_serial3.sv - serial a - b - bin, one 3-bit slice per clock
// Optional signed-overflow output enabled by SUB_SERIAL3_OVF_EN.
module sub_serial3
  import sub_serial3_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SERIAL3_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = slice_count(WIDTH);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("sub_serial3: WIDTH must be a positive multiple of 3");
  end

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_borrow;
  logic               last;
  logic               accept;
  logic [WIDTH+SLICE_W-1:0] diff_cat;

  assign last     = (cnt == CNT_W'(N - 1));
  assign accept   = in_valid && in_ready;
  // Result fills from the top so that slice 0 ends up in the low bits after N shifts
  assign diff_cat = {slice_d, diff};

  sub_slice3 u_slice (
    .a          (a_r[SLICE_W-1:0]),
    .b          (b_r[SLICE_W-1:0]),
    .borrow     (borrow),
    .d          (slice_d),
    .borrow_out (slice_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SUB_SERIAL3_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (accept) begin
        a_r    <= a;
        b_r    <= b;
        cnt    <= '0;
        borrow <= bin;
      end
    end else if (state == RUN) begin
      // Operands shift down so the active slice always sits in bits [2:0]
      a_r    <= a_r >> SLICE_W;
      b_r    <= b_r >> SLICE_W;
      diff   <= diff_cat[WIDTH+SLICE_W-1:SLICE_W];
      borrow <= slice_borrow;
      if (last) begin
        bout <= slice_borrow;
`ifdef SUB_SERIAL3_OVF_EN
        ovf  <= (a_r[SLICE_W-1] != b_r[SLICE_W-1]) && (slice_d[SLICE_W-1] != a_r[SLICE_W-1]);
`endif
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sub_serial3.sv
// tb/tb_sub_serial3.sv - randomized self-checking bench for sub_serial3 (WIDTH=12)
module tb_sub_serial3;

  localparam int WIDTH = 12;
  localparam int N     = 4;
  localparam int LAT   = N;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_SERIAL3_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  sub_serial3 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_SERIAL3_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on whole operands, returns {ovf, bout, diff}
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                              input logic mbin);
    int ua, ub, r, sa, sb, sr;
    logic [WIDTH-1:0] d;
    logic bo, ov;
    ua = int'(ma);
    ub = int'(mb);
    r  = ua - ub - int'(mbin);
    d  = r[WIDTH-1:0];
    bo = (ua < ub + int'(mbin));
    sa = (ua >= (1 << (WIDTH - 1))) ? ua - (1 << WIDTH) : ua;
    sb = (ub >= (1 << (WIDTH - 1))) ? ub - (1 << WIDTH) : ub;
    sr = sa - sb - int'(mbin);
    ov = (sr < -(1 << (WIDTH - 1))) || (sr > (1 << (WIDTH - 1)) - 1);
    return {ov, bo, d};
  endfunction

  task automatic check_result(input string tag, input logic [WIDTH+1:0] exp);
    check({tag, "_diff"}, 32'(diff), 32'(exp[WIDTH-1:0]));
    check({tag, "_bout"}, 32'(bout), 32'(exp[WIDTH]));
`ifdef SUB_SERIAL3_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp[WIDTH+1]));
`endif
  endtask

  // Called #1 after an edge; the accept happens on the next edge
  task automatic start_op(input string tag, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                          input logic obin);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs afterwards: they must have no effect on the running op
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic full_op(input string tag, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                         input logic obin, input int stall);
    logic [WIDTH+1:0] exp;
    exp = model(oa, ob, obin);
    start_op(tag, oa, ob, obin);
    wait_valid(tag);
    check_result(tag, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
    end
    if (stall > 0) check_result({tag, "_held"}, exp);
    finish_op(tag);
  endtask

  initial begin
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] ra, rb;
    logic rbin;
    logic [WIDTH+1:0] q[$];
    int cyc, accepts, results, last_acc;
    logic acc_now;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check_result("rst", '0);
    rst = 1'b0;
    @(posedge clk); #1;

    full_op("basic", 12'h123, 12'h045, 1'b0, 0);
    check("basic_const", 32'(model(12'h123, 12'h045, 1'b0)), 32'h0DE);
    full_op("wrap", 12'h000, 12'h001, 1'b0, 0);
    full_op("binovf", 12'h800, 12'h000, 1'b1, 0);

    // Backpressure: results held, in_valid ignored while DONE
    exp = model(12'h5A5, 12'h3C3, 1'b1);
    start_op("bp", 12'h5A5, 12'h3C3, 1'b1);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      a = 12'hFFF; b = 12'h000; bin = 1'b0;
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(in_ready), 32'd0);
      check_result("bp", exp);
    end
    in_valid = 1'b0;
    finish_op("bp");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    check("bp_no_ghost", 32'(out_valid), 32'd0);

    // Reset mid-RUN after two slices
    start_op("mid", 12'h7E1, 12'h123, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check_result("mid_rst", '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    full_op("after_rst", 12'hFFF, 12'hFFF, 1'b0, 0);

    // Random single ops with random stall
    for (int k = 0; k < 20; k++) begin
      full_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back with both handshakes held high
    cyc = 0; accepts = 0; results = 0; last_acc = -1;
    ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom);
    a = ra; b = rb; bin = rbin;
    in_valid = 1'b1; out_ready = 1'b1;
    while (results < 3 && cyc < 200) begin
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        q.push_back(model(a, b, bin));
        if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'(N + 2));
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        accepts++;
        if (accepts < 3) begin
          a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (q.size() > 0) begin
          check_result("b2b", q.pop_front());
        end else begin
          check("b2b_unexpected_valid", 32'd1, 32'd0);
        end
        results++;
      end
    end
    check("b2b_results", 32'(results), 32'd3);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
